// File: rtl/imem_boot_loader.sv
// Boot loader: clears instruction memory, assembles IN_WIDTH-bit beats into words,
// writes them from address 0, verifies an XOR checksum and releases the core.
module imem_boot_loader #(
  parameter int PC_SIZE     = 10,
  parameter int INSTR_WIDTH = 32,
  parameter int IN_WIDTH    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PC_SIZE:0]       len,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   imem_clear,
  output logic                   imem_we,
  output logic [PC_SIZE-1:0]     imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_data,
  output logic                   core_reset,
  output logic [PC_SIZE:0]       words_loaded,
  output logic                   done,
  output logic                   error
);

  localparam int BEATS = INSTR_WIDTH / IN_WIDTH;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [PC_SIZE:0] DEPTH     = {1'b1, {PC_SIZE{1'b0}}};
  localparam logic [BCW-1:0]   LAST_BEAT = BCW'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, WRITE, CHECK, RUN, ERROR} state_t;
  state_t state, state_nx;

  logic [PC_SIZE:0]       len_q;
  logic [BCW-1:0]         beat_cnt;
  logic [INSTR_WIDTH-1:0] sreg, csum, word_nx;
  logic                   beat_acc, last_beat, start_ok;

  assign beat_acc  = in_valid & in_ready;
  assign last_beat = beat_acc && (beat_cnt == LAST_BEAT);
  assign start_ok  = start && (state == IDLE || state == RUN || state == ERROR);

  // Beats shift in from the top so the first beat ends up in the LSBs.
  generate
    if (BEATS == 1) begin : g_single
      assign word_nx = in_data;
    end else begin : g_multi
      assign word_nx = {in_data, sreg[INSTR_WIDTH-1:IN_WIDTH]};
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, RUN, ERROR: if (start) state_nx = (len > DEPTH) ? ERROR : CLEAR;
      CLEAR:            state_nx = LOAD;
      LOAD:             if (last_beat) state_nx = (words_loaded < len_q) ? WRITE : CHECK;
      WRITE:            state_nx = LOAD;
      CHECK:            state_nx = (sreg == csum) ? RUN : ERROR;
      default:          state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered and Moore.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_ready     <= 1'b0;
      imem_clear   <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_data    <= '0;
      core_reset   <= 1'b1;
      words_loaded <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      len_q        <= '0;
      beat_cnt     <= '0;
      sreg         <= '0;
      csum         <= '0;
    end else begin
      in_ready   <= (state_nx == LOAD);
      imem_clear <= (state_nx == CLEAR);
      imem_we    <= (state_nx == WRITE);
      core_reset <= (state_nx != RUN);
      done       <= (state_nx == RUN);
      error      <= (state_nx == ERROR);
      if (start_ok) begin
        len_q        <= len;
        beat_cnt     <= '0;
        sreg         <= '0;
        csum         <= '0;
        words_loaded <= '0;
        imem_addr    <= '0;
        imem_data    <= '0;
      end else begin
        if (beat_acc) begin
          sreg     <= word_nx;
          beat_cnt <= last_beat ? '0 : beat_cnt + BCW'(1);
        end
        // Address uses the pre-increment count, so len=DEPTH ends at DEPTH-1.
        if (state == LOAD && state_nx == WRITE) begin
          imem_addr    <= words_loaded[PC_SIZE-1:0];
          imem_data    <= word_nx;
          csum         <= csum ^ word_nx;
          words_loaded <= words_loaded + (PC_SIZE+1)'(1);
        end
      end
    end
  end

endmodule
